// File: rtl/hex_dump_pkg.sv
// Shared definitions for the hex dump writer: FSM state encoding and the
// ASCII constants used to build "xx\n" lines.
package hex_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HI    = 3'd3,
    ST_LO    = 3'd4,
    ST_NL    = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_A_UC = 8'h41;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational 4-bit nibble to ASCII hex digit; UPPER picks 'A'-'F' vs 'a'-'f'.
module hex_nibble_ascii
  import hex_dump_pkg::*;
#(
  parameter bit UPPER = 1'b0
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  localparam logic [7:0] ALPHA_BASE = UPPER ? ASCII_A_UC : ASCII_A_LC;

  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_0 + {4'd0, nibble};
    else                ascii = ALPHA_BASE + {4'd0, nibble} - 8'd10;
  end

endmodule

// File: rtl/hex_dump_writer.sv
// Streams a byte-wide RAM out as hex-load-format text, one "xx<EOL>" line per
// byte, reading through a 1-cycle synchronous port onto a valid/ready stream.
module hex_dump_writer
  import hex_dump_pkg::*;
#(
  parameter int         ADDR_W = 12,
  parameter int         DEPTH  = 3001,
  parameter int         UPPER  = 0,
  parameter logic [7:0] EOL    = ASCII_LF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_bytes,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   len;
  logic [7:0]        data_q;
  logic [7:0]        hi_char, lo_char;
  logic              last;

  hex_nibble_ascii #(.UPPER(UPPER != 0)) u_hi (.nibble(data_q[7:4]), .ascii(hi_char));
  hex_nibble_ascii #(.UPPER(UPPER != 0)) u_lo (.nibble(data_q[3:0]), .ascii(lo_char));

  assign last     = (({1'b0, idx} + (ADDR_W+1)'(1)) == len);
  assign mem_addr = idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          busy     = (num_bytes != '0);
          state_nx = (num_bytes == '0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        state_nx  = ST_WAIT;
      end
      ST_WAIT: begin
        busy     = 1'b1;
        state_nx = ST_HI;
      end
      ST_HI: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = hi_char;
        if (tx_ready) state_nx = ST_LO;
      end
      ST_LO: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = lo_char;
        if (tx_ready) state_nx = ST_NL;
      end
      ST_NL: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = EOL;
        if (tx_ready) state_nx = last ? ST_FIN : ST_FETCH;
      end
      ST_FIN: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Index holds at len-1 on the final line so the address never runs past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      len    <= '0;
      data_q <= 8'h00;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            len <= (num_bytes > DEPTH_L) ? DEPTH_L : num_bytes;
            idx <= '0;
          end
        end
        ST_WAIT: data_q <= mem_rdata;
        ST_NL:   if (tx_ready && !last) idx <= idx + ADDR_W'(1);
        ST_FIN:  idx <= '0;
        default: ;
      endcase
    end
  end

endmodule
